// File: rtl/fpu_add_subt_dispatch_if.sv
// Handshake and core-side bundle for the add/subtract dispatcher.
// Signal directions are named from the dispatcher's point of view.
interface fpu_add_subt_dispatch_if #(
   parameter int W = 32
);
   logic         req_valid_i;
   logic         req_ready_o;
   logic [W-1:0] op_a_i;
   logic [W-1:0] op_b_i;
   logic         add_subt_i;
   logic         beg_FSM_o;
   logic         rst_FSM_o;
   logic         core_abort_o;
   logic [W-1:0] oper_a_o;
   logic [W-1:0] oper_b_o;
   logic         add_subt_o;
   logic         core_ready_i;
   logic [W-1:0] core_result_i;
   logic         core_ovf_i;
   logic         core_unf_i;
   logic         res_valid_o;
   logic         res_ready_i;
   logic [W-1:0] result_o;
   logic         ovf_o;
   logic         unf_o;
   logic         timeout_o;
   logic         busy_o;

   modport slave (
      input  req_valid_i, op_a_i, op_b_i, add_subt_i,
             core_ready_i, core_result_i, core_ovf_i, core_unf_i, res_ready_i,
      output req_ready_o, beg_FSM_o, rst_FSM_o, core_abort_o,
             oper_a_o, oper_b_o, add_subt_o,
             res_valid_o, result_o, ovf_o, unf_o, timeout_o, busy_o
   );

   modport master (
      output req_valid_i, op_a_i, op_b_i, add_subt_i,
             core_ready_i, core_result_i, core_ovf_i, core_unf_i, res_ready_i,
      input  req_ready_o, beg_FSM_o, rst_FSM_o, core_abort_o,
             oper_a_o, oper_b_o, add_subt_o,
             res_valid_o, result_o, ovf_o, unf_o, timeout_o, busy_o
   );
endinterface

// File: rtl/fpu_add_subt_dispatch.sv
// Front-end sequencer for the add/subtract core: launch, wait with watchdog,
// capture result, release the core and hand the result downstream.
//
// state   | meaning
// IDLE    | ready for a request; operands latched on acceptance
// LAUNCH  | one-cycle begin strobe to the core
// WAIT    | waiting for core ready; watchdog counting
// RELEASE | one-cycle rst_FSM strobe after a good capture
// ABORT   | one-cycle abort strobe after watchdog expiry
// HOLD    | result valid until consumed
module fpu_add_subt_dispatch #(
   parameter int W       = 32,
   parameter int TIMEOUT = 64,
   parameter int CW      = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   fpu_add_subt_dispatch_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_WAIT    = 3'd2,
      S_RELEASE = 3'd3,
      S_ABORT   = 3'd4,
      S_HOLD    = 3'd5
   } state_t;

   localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   oper_a_q, oper_a_d;
   logic [W-1:0]   oper_b_q, oper_b_d;
   logic           add_subt_q, add_subt_d;
   logic [W-1:0]   result_q, result_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;
   logic           timeout_q, timeout_d;
   logic           req_ready, beg_fsm, rst_fsm, core_abort, res_valid, busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         oper_a_q   <= '0;
         oper_b_q   <= '0;
         add_subt_q <= 1'b0;
         result_q   <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         oper_a_q   <= oper_a_d;
         oper_b_q   <= oper_b_d;
         add_subt_q <= add_subt_d;
         result_q   <= result_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         timeout_q  <= timeout_d;
      end
   end

   // Core ready takes priority over the watchdog terminal count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.req_valid_i) state_d = S_LAUNCH;
         S_LAUNCH:  state_d = S_WAIT;
         S_WAIT: begin
            if (bus.core_ready_i)  state_d = S_RELEASE;
            else if (cnt_q == TERM) state_d = S_ABORT;
         end
         S_RELEASE: state_d = S_HOLD;
         S_ABORT:   state_d = S_HOLD;
         S_HOLD:    if (bus.res_ready_i) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      oper_a_d   = oper_a_q;
      oper_b_d   = oper_b_q;
      add_subt_d = add_subt_q;
      result_d   = result_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      timeout_d  = timeout_q;
      if (state_q == S_IDLE && bus.req_valid_i) begin
         oper_a_d   = bus.op_a_i;
         oper_b_d   = bus.op_b_i;
         add_subt_d = bus.add_subt_i;
         cnt_d      = '0;
      end
      if (state_q == S_WAIT) begin
         if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
         if (bus.core_ready_i) begin
            result_d  = bus.core_result_i;
            ovf_d     = bus.core_ovf_i;
            unf_d     = bus.core_unf_i;
            timeout_d = 1'b0;
         end else if (cnt_q == TERM) begin
            result_d  = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            timeout_d = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready  = (state_q == S_IDLE);
      beg_fsm    = (state_q == S_LAUNCH);
      rst_fsm    = (state_q == S_RELEASE);
      core_abort = (state_q == S_ABORT);
      res_valid  = (state_q == S_HOLD);
      busy       = (state_q != S_IDLE);
   end

   assign bus.req_ready_o  = req_ready;
   assign bus.beg_FSM_o    = beg_fsm;
   assign bus.rst_FSM_o    = rst_fsm;
   assign bus.core_abort_o = core_abort;
   assign bus.res_valid_o  = res_valid;
   assign bus.busy_o       = busy;
   assign bus.oper_a_o     = oper_a_q;
   assign bus.oper_b_o     = oper_b_q;
   assign bus.add_subt_o   = add_subt_q;
   assign bus.result_o     = result_q;
   assign bus.ovf_o        = ovf_q;
   assign bus.unf_o        = unf_q;
   assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_fpu_add_subt_dispatch.sv
// Directed bench for the add/subtract dispatcher with a hand-driven core model.
module tb_fpu_add_subt_dispatch;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   beg_cnt  = 0;
   int   rfsm_cnt = 0;
   int   abort_cnt = 0;
   int   snap_beg, snap_rfsm, snap_abort;

   fpu_add_subt_dispatch_if #(.W(32)) bus ();

   fpu_add_subt_dispatch #(.W(32), .TIMEOUT(16), .CW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.beg_FSM_o)    beg_cnt   <= beg_cnt + 1;
      if (bus.rst_FSM_o)    rfsm_cnt  <= rfsm_cnt + 1;
      if (bus.core_abort_o) abort_cnt <= abort_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL tb_time_limit observed=expired expected=finished");
      $fatal(1, "time limit");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic sub);
      bus.op_a_i      = a;
      bus.op_b_i      = b;
      bus.add_subt_i  = sub;
      bus.req_valid_i = 1'b1;
      tick();
      chk1("beg_launch", bus.beg_FSM_o, 1'b1);
      chk1("req_ready_busy", bus.req_ready_o, 1'b0);
      chkw("oper_a", bus.oper_a_o, a);
      chkw("oper_b", bus.oper_b_o, b);
      chk1("add_subt", bus.add_subt_o, sub);
      bus.req_valid_i = 1'b0;
   endtask

   task automatic complete(input int waitc, input logic [31:0] res,
                           input logic ovf, input logic unf);
      tick();
      chk1("beg_once", bus.beg_FSM_o, 1'b0);
      repeat (waitc) tick();
      bus.core_ready_i  = 1'b1;
      bus.core_result_i = res;
      bus.core_ovf_i    = ovf;
      bus.core_unf_i    = unf;
      tick();
      chk1("rst_fsm_pulse", bus.rst_FSM_o, 1'b1);
      chk1("no_valid_in_release", bus.res_valid_o, 1'b0);
      bus.core_ready_i  = 1'b0;
      bus.core_result_i = 32'hDEADBEEF;
      bus.core_ovf_i    = ~ovf;
      bus.core_unf_i    = ~unf;
      tick();
      chk1("res_valid", bus.res_valid_o, 1'b1);
      chk1("rst_fsm_once", bus.rst_FSM_o, 1'b0);
      chkw("result", bus.result_o, res);
      chk1("ovf", bus.ovf_o, ovf);
      chk1("unf", bus.unf_o, unf);
      chk1("timeout_clear", bus.timeout_o, 1'b0);
   endtask

   task automatic release_res;
      bus.res_ready_i = 1'b1;
      tick();
      chk1("idle_valid_low", bus.res_valid_o, 1'b0);
      chk1("idle_req_ready", bus.req_ready_o, 1'b1);
      bus.res_ready_i = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      bus.req_valid_i   = 1'b0;
      bus.op_a_i        = '0;
      bus.op_b_i        = '0;
      bus.add_subt_i    = 1'b0;
      bus.core_ready_i  = 1'b0;
      bus.core_result_i = '0;
      bus.core_ovf_i    = 1'b0;
      bus.core_unf_i    = 1'b0;
      bus.res_ready_i   = 1'b0;

      tick();
      tick();
      chk1("rst_req_ready", bus.req_ready_o, 1'b1);
      chk1("rst_busy", bus.busy_o, 1'b0);
      chk1("rst_beg", bus.beg_FSM_o, 1'b0);
      chk1("rst_res_valid", bus.res_valid_o, 1'b0);
      chkw("rst_result", bus.result_o, 32'h0);
      chkw("rst_oper_a", bus.oper_a_o, 32'h0);
      chk1("rst_timeout", bus.timeout_o, 1'b0);
      rst = 1'b1;
      tick();

      // 1.0 + 2.0 = 3.0
      accept(32'h3F800000, 32'h40000000, 1'b0);
      complete(3, 32'h40400000, 1'b0, 1'b0);
      release_res();
      chkw("one_beg_pulse", beg_cnt, 1);
      chkw("one_rst_fsm_pulse", rfsm_cnt, 1);

      // 0.0 - 5.0 = -5.0, core ready on the first WAIT cycle
      accept(32'h00000000, 32'h40A00000, 1'b1);
      complete(0, 32'hC0A00000, 1'b0, 1'b0);
      release_res();

      // Backpressure with an overflowing op, then a queued 1.5 + 0.5
      accept(32'h7F000000, 32'h7F000000, 1'b0);
      complete(2, 32'h7F800000, 1'b1, 1'b0);
      bus.op_a_i      = 32'h3FC00000;
      bus.op_b_i      = 32'h3F000000;
      bus.add_subt_i  = 1'b0;
      bus.req_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chkw("bp_result_stable", bus.result_o, 32'h7F800000);
         chk1("bp_req_ready", bus.req_ready_o, 1'b0);
         chk1("bp_res_valid", bus.res_valid_o, 1'b1);
         chkw("bp_oper_a_held", bus.oper_a_o, 32'h7F000000);
      end
      bus.res_ready_i = 1'b1;
      tick();
      chk1("bp_to_idle", bus.req_ready_o, 1'b1);
      chk1("bp_busy", bus.busy_o, 1'b0);
      bus.res_ready_i = 1'b0;
      tick();
      chk1("queued_beg", bus.beg_FSM_o, 1'b1);
      chkw("queued_oper_a", bus.oper_a_o, 32'h3FC00000);
      bus.req_valid_i = 1'b0;
      complete(1, 32'h40000000, 1'b0, 1'b0);
      release_res();

      // Watchdog: core never answers
      accept(32'h3F800000, 32'h3F800000, 1'b0);
      tick();
      for (int i = 0; i < 15; i++) tick();
      chk1("to_no_abort_yet", bus.core_abort_o, 1'b0);
      chk1("to_still_busy", bus.busy_o, 1'b1);
      tick();
      chk1("to_abort", bus.core_abort_o, 1'b1);
      chk1("to_abort_no_valid", bus.res_valid_o, 1'b0);
      tick();
      chk1("to_abort_once", bus.core_abort_o, 1'b0);
      chk1("to_res_valid", bus.res_valid_o, 1'b1);
      chkw("to_result", bus.result_o, 32'h0);
      chk1("to_ovf", bus.ovf_o, 1'b0);
      chk1("to_timeout", bus.timeout_o, 1'b1);
      release_res();
      chkw("to_abort_count", abort_cnt, 1);

      // Ready exactly at the terminal count: 3.0 - 1.0 = 2.0
      accept(32'h40400000, 32'h3F800000, 1'b1);
      complete(15, 32'h40000000, 1'b0, 1'b1);
      chkw("tc_no_abort", abort_cnt, 1);
      release_res();

      // Reset in the middle of WAIT
      accept(32'h40A00000, 32'h40A00000, 1'b0);
      tick();
      tick();
      snap_beg   = beg_cnt;
      snap_rfsm  = rfsm_cnt;
      snap_abort = abort_cnt;
      rst = 1'b0;
      #1;
      chk1("mr_busy", bus.busy_o, 1'b0);
      chk1("mr_req_ready", bus.req_ready_o, 1'b1);
      chkw("mr_oper_a", bus.oper_a_o, 32'h0);
      chkw("mr_result", bus.result_o, 32'h0);
      chk1("mr_unf", bus.unf_o, 1'b0);
      chk1("mr_res_valid", bus.res_valid_o, 1'b0);
      tick();
      tick();
      chkw("mr_no_beg", beg_cnt, snap_beg);
      chkw("mr_no_rfsm", rfsm_cnt, snap_rfsm);
      chkw("mr_no_abort", abort_cnt, snap_abort);
      rst = 1'b1;
      tick();

      // 5.0 + 5.0 = 10.0 after reset
      accept(32'h40A00000, 32'h40A00000, 1'b0);
      complete(1, 32'h41200000, 1'b0, 1'b0);
      release_res();

      chkw("total_beg", beg_cnt, 8);
      chkw("total_rst_fsm", rfsm_cnt, 6);
      chkw("total_abort", abort_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
